// File: rtl/ysyx_25010008_lsu_axi.sv
// -----------------------------------------------------------------------------
// ysyx_25010008_lsu_axi
//
// Load/store unit front end that turns single CPU memory requests into
// AXI4-Lite transactions. One request is in flight at a time. Each request
// ends with a one-cycle completion pulse that carries the extended load data
// and an error code.
//
// Parameters
//   DATA_W  data bus width, 32 or 64
//   ADDR_W  byte address width
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   req_valid / req_ready   request handshake (accepted when both are high)
//   req_we                  1 = store, 0 = load
//   req_size                0 byte, 1 half, 2 word, 3 double (DATA_W=64 only)
//   req_sext                sign-extend (1) or zero-extend (0) the load result
//   req_addr, req_wdata     byte address and LSB-aligned store data
//   resp_valid              one-cycle completion pulse
//   resp_rdata              extended load result, 0 for stores and errors
//   resp_err                00 ok, 01 misaligned / illegal size, 10 bus error
//   ar*, r*                 AXI4-Lite read address and read data channels
//   aw*, w*, b*             AXI4-Lite write address, write data and response
// -----------------------------------------------------------------------------
module ysyx_25010008_lsu_axi #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    // CPU request / response
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_err,

    // AXI4-Lite read channels
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,

    // AXI4-Lite write channels
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    localparam logic [DATA_W-1:0] DATA_ONES = '1;
    localparam logic [STRB_W-1:0] STRB_ONES = '1;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        BRESP,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    // Request fields captured at acceptance; the load/store choice is carried
    // by the state itself (RADDR/RDATA versus WREQ/BRESP).
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [DATA_W-1:0] wdata_q;

    // Write address / write data channels complete independently.
    logic aw_done;
    logic w_done;

    logic              accept;
    logic              misaligned;
    logic [OFF_W-1:0]  off;
    logic [ADDR_W-1:0] bus_addr;

    logic [DATA_W-1:0] load_shifted;
    logic [DATA_W-1:0] load_keep;
    logic              load_sign;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] store_data;
    logic [STRB_W-1:0] store_bytes;
    logic [STRB_W-1:0] store_strb;

    // Gating with reset keeps req_ready low for the whole reset window,
    // including the asynchronous part before any clock edge.
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // A request is illegal when the address is not a multiple of the access
    // size, or when a double is requested on a 32-bit bus.
    always_comb begin
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = (DATA_W == 32) || (|req_addr[2:0]);
        endcase
    end

    assign off      = addr_q[OFF_W-1:0];
    assign bus_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // -------------------------------------------------------------------------
    // Load data path: move the addressed bytes down to bit 0, keep 2^size
    // bytes and extend. A shift by 8 << size that reaches the full bus width
    // yields zero, so keep becomes all ones for a full-width access.
    // -------------------------------------------------------------------------
    always_comb begin
        load_shifted = rdata >> {off, 3'b000};
        load_keep    = ~(DATA_ONES << (8 << size_q));
        case (size_q)
            2'd0:    load_sign = load_shifted[7];
            2'd1:    load_sign = load_shifted[15];
            2'd2:    load_sign = load_shifted[31];
            default: load_sign = load_shifted[DATA_W-1];
        endcase
        load_ext = (load_shifted & load_keep) |
                   ((sext_q && load_sign) ? ~load_keep : '0);
    end

    // -------------------------------------------------------------------------
    // Store data path: place the LSB-aligned data at the byte offset and
    // enable exactly 2^size byte lanes starting at that offset.
    // -------------------------------------------------------------------------
    always_comb begin
        store_data  = wdata_q << {off, 3'b000};
        store_bytes = ~(STRB_ONES << (1 << size_q));
        store_strb  = store_bytes << off;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and bus-side outputs. All bus outputs are zero outside the
    // state that owns them, so a reset (which forces IDLE) silences the bus.
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        arvalid    = 1'b0;
        araddr     = '0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        awaddr     = '0;
        wvalid     = 1'b0;
        wdata      = '0;
        wstrb      = '0;
        bready     = 1'b0;
        resp_valid = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else if (req_we) begin
                        state_next = WREQ;
                    end else begin
                        state_next = RADDR;
                    end
                end
            end

            RADDR: begin
                arvalid = 1'b1;
                araddr  = bus_addr;
                if (arready) begin
                    state_next = RDATA;
                end
            end

            RDATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_next = RESP;
                end
            end

            WREQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                awaddr  = bus_addr;
                wdata   = store_data;
                wstrb   = store_strb;
                // Leave once both channels have handshaken, whether earlier
                // (done flag) or on this edge (ready with valid still high).
                if ((aw_done || awready) && (w_done || wready)) begin
                    state_next = BRESP;
                end
            end

            BRESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = RESP;
                end
            end

            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            sext_q  <= req_sext;
            wdata_q <= req_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel write handshake tracking
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (accept) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WREQ) begin
            if (awvalid && awready) begin
                aw_done <= 1'b1;
            end
            if (wvalid && wready) begin
                w_done <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response registers: loaded on the edge that enters RESP and held until
    // the next response is produced.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
        end else begin
            if (accept && misaligned) begin
                resp_rdata <= '0;
                resp_err   <= ERR_ALIGN;
            end else if ((state == RDATA) && rvalid) begin
                if (rresp != 2'b00) begin
                    resp_rdata <= '0;
                    resp_err   <= ERR_BUS;
                end else begin
                    resp_rdata <= load_ext;
                    resp_err   <= ERR_OK;
                end
            end else if ((state == BRESP) && bvalid) begin
                resp_rdata <= '0;
                resp_err   <= (bresp != 2'b00) ? ERR_BUS : ERR_OK;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_lsu_axi.sv
// -----------------------------------------------------------------------------
// tb_ysyx_25010008_lsu_axi
//
// Drives a 32-bit LSU through loads, stores, illegal requests, bus errors and
// a mid-transaction reset, acting as the AXI4-Lite slave. Expected responses
// are queued when a request is issued and compared by a monitor whenever
// resp_valid pulses. A second, 64-bit instance covers the wide-bus offset case.
// -----------------------------------------------------------------------------
module tb_ysyx_25010008_lsu_axi;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    // 32-bit DUT signals
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    // 64-bit DUT signals
    logic        x_req_valid, x_req_ready, x_req_we, x_req_sext;
    logic [1:0]  x_req_size;
    logic [31:0] x_req_addr;
    logic [63:0] x_req_wdata;
    logic        x_resp_valid;
    logic [63:0] x_resp_rdata;
    logic [1:0]  x_resp_err;
    logic [31:0] x_araddr, x_awaddr;
    logic [63:0] x_rdata, x_wdata;
    logic        x_arvalid, x_arready, x_rvalid, x_rready;
    logic [1:0]  x_rresp, x_bresp;
    logic        x_awvalid, x_awready, x_wvalid, x_wready, x_bvalid, x_bready;
    logic [7:0]  x_wstrb;

    ysyx_25010008_lsu_axi #(.DATA_W(32), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    ysyx_25010008_lsu_axi #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clock(clock), .reset(reset),
        .req_valid(x_req_valid), .req_ready(x_req_ready), .req_we(x_req_we),
        .req_size(x_req_size), .req_sext(x_req_sext), .req_addr(x_req_addr),
        .req_wdata(x_req_wdata), .resp_valid(x_resp_valid),
        .resp_rdata(x_resp_rdata), .resp_err(x_resp_err),
        .araddr(x_araddr), .arvalid(x_arvalid), .arready(x_arready),
        .rdata(x_rdata), .rresp(x_rresp), .rvalid(x_rvalid), .rready(x_rready),
        .awaddr(x_awaddr), .awvalid(x_awvalid), .awready(x_awready),
        .wdata(x_wdata), .wstrb(x_wstrb), .wvalid(x_wvalid), .wready(x_wready),
        .bresp(x_bresp), .bvalid(x_bvalid), .bready(x_bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } resp_t;

    resp_t sb_q[$];
    resp_t sb_head;

    int cycle = 0;
    int resp_count = 0;
    int resp_cycle = 0;

    always @(posedge clock) cycle <= cycle + 1;

    // Response monitor: every completion pulse is matched to the oldest
    // outstanding expectation.
    always @(negedge clock) begin
        if (resp_valid) begin
            resp_count++;
            resp_cycle = cycle;
            if (sb_q.size() == 0) begin
                check("spurious_resp", resp_valid, 1'b0);
            end else begin
                sb_head = sb_q.pop_front();
                check("resp_rdata", resp_rdata, sb_head.rdata);
                check("resp_err", resp_err, sb_head.err);
            end
        end
    end

    // Slave side of a load: optional wait before arready and before rvalid.
    task automatic slave_read(input string name, input logic [31:0] exp_addr,
                              input logic [31:0] bus_rd, input logic [1:0] bus_resp,
                              input int a_w, input int d_w);
        int n = 0;
        while (!arvalid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({name, "_arvalid"}, arvalid, 1'b1);
        check({name, "_araddr"}, araddr, exp_addr);
        repeat (a_w) @(negedge clock);
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        check({name, "_arvalid_drop"}, arvalid, 1'b0);
        repeat (d_w) @(negedge clock);
        check({name, "_rready"}, rready, 1'b1);
        rdata  = bus_rd;
        rresp  = bus_resp;
        rvalid = 1'b1;
        @(negedge clock);
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
    endtask

    // Slave side of a store: independent waits on awready and wready.
    task automatic slave_write(input string name, input logic [31:0] exp_addr,
                               input logic [31:0] exp_wd, input logic [3:0] exp_strb,
                               input logic [1:0] bus_resp,
                               input int a_w, input int d_w, input int b_w);
        int n = 0;
        while (!(awvalid && wvalid) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({name, "_awvalid"}, awvalid, 1'b1);
        check({name, "_wvalid"}, wvalid, 1'b1);
        check({name, "_awaddr"}, awaddr, exp_addr);
        check({name, "_wdata"}, wdata, exp_wd);
        check({name, "_wstrb"}, wstrb, exp_strb);
        fork
            begin
                repeat (a_w) @(negedge clock);
                awready = 1'b1;
                @(negedge clock);
                awready = 1'b0;
                check({name, "_awvalid_drop"}, awvalid, 1'b0);
            end
            begin
                repeat (d_w) @(negedge clock);
                wready = 1'b1;
                @(negedge clock);
                wready = 1'b0;
                check({name, "_wvalid_drop"}, wvalid, 1'b0);
            end
        join
        repeat (b_w) @(negedge clock);
        check({name, "_bready"}, bready, 1'b1);
        bresp  = bus_resp;
        bvalid = 1'b1;
        @(negedge clock);
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    // One complete request. exp_lat = 0 skips the latency comparison.
    task automatic run_req(input string name, input logic we, input logic [1:0] size,
                           input logic sext, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] bus_rd, input logic [1:0] bus_resp,
                           input logic [31:0] exp_baddr, input logic [31:0] exp_wd,
                           input logic [3:0] exp_strb, input logic [31:0] exp_rd,
                           input logic [1:0] exp_err, input int a_w, input int d_w,
                           input int b_w, input int exp_lat);
        int    start;
        int    n;
        int    acc_cyc;
        resp_t exp_r;
        start       = resp_count;
        exp_r.rdata = exp_rd;
        exp_r.err   = exp_err;
        sb_q.push_back(exp_r);

        @(negedge clock);
        req_we    = we;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        check({name, "_req_ready"}, req_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        acc_cyc   = cycle;
        req_valid = 1'b0;
        req_wdata = '0;

        if (exp_err == 2'b01) begin
            check({name, "_no_arvalid"}, arvalid, 1'b0);
            check({name, "_no_awvalid"}, awvalid, 1'b0);
        end else if (!we) begin
            slave_read(name, exp_baddr, bus_rd, bus_resp, a_w, d_w);
        end else begin
            slave_write(name, exp_baddr, exp_wd, exp_strb, bus_resp, a_w, d_w, b_w);
        end

        n = 0;
        while (resp_count == start && n < 100) begin
            @(posedge clock);
            n++;
        end
        check({name, "_resp_count"}, resp_count - start, 1);
        if (exp_lat != 0) begin
            check({name, "_latency"}, resp_cycle - acc_cyc + 1, exp_lat);
        end

        @(negedge clock);
        check({name, "_pulse_end"}, resp_valid, 1'b0);
        check({name, "_hold_rdata"}, resp_rdata, exp_rd);
        check({name, "_hold_err"}, resp_err, exp_err);
        check({name, "_bus_quiet"}, {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        req_valid = 0; req_we = 0; req_size = 0; req_sext = 0; req_addr = 0; req_wdata = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        x_req_valid = 0; x_req_we = 0; x_req_size = 0; x_req_sext = 0;
        x_req_addr = 0; x_req_wdata = 0;
        x_arready = 0; x_rdata = 0; x_rresp = 0; x_rvalid = 0;
        x_awready = 0; x_wready = 0; x_bresp = 0; x_bvalid = 0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp", {resp_rdata, resp_err}, 34'h0);
        check("rst_bus", {arvalid, rready, awvalid, wvalid, bready, wstrb}, 9'h0);
        check("rst_req_ready64", x_req_ready, 1'b0);
        reset = 1'b0;
        #1 check("post_rst_req_ready", req_ready, 1'b1);

        //      name   we  sz sx addr          wdata         bus_rd        rsp   baddr         exp_wd        strb     exp_rd        err   aw dw bw lat
        run_req("lb",  0, 0, 1, 32'h8000_0003, 32'h0,        32'h80FF_1234, 2'd0, 32'h8000_0000, 32'h0,        4'b0000, 32'hFFFF_FF80, 2'b00, 0, 0, 0, 3);
        run_req("lbu", 0, 0, 0, 32'h8000_0003, 32'h0,        32'h80FF_1234, 2'd0, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_0080, 2'b00, 0, 0, 0, 3);
        run_req("lh",  0, 1, 1, 32'h8000_0002, 32'h0,        32'h80FF_1234, 2'd0, 32'h8000_0000, 32'h0,        4'b0000, 32'hFFFF_80FF, 2'b00, 0, 0, 0, 3);
        run_req("lhu", 0, 1, 0, 32'h8000_0000, 32'h0,        32'h80FF_1234, 2'd0, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_1234, 2'b00, 0, 0, 0, 3);
        run_req("lhp", 0, 1, 1, 32'h8000_0000, 32'h0,        32'h0000_7FFF, 2'd0, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_7FFF, 2'b00, 0, 0, 0, 3);
        run_req("lw",  0, 2, 0, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 2'd0, 32'h8000_0004, 32'h0,        4'b0000, 32'hDEAD_BEEF, 2'b00, 2, 1, 0, 0);
        run_req("sh",  1, 1, 0, 32'h8000_0002, 32'h0000_ABCD, 32'h0,       2'd0, 32'h8000_0000, 32'hABCD_0000, 4'b1100, 32'h0,         2'b00, 0, 2, 0, 0);
        run_req("sb",  1, 0, 0, 32'h8000_0001, 32'h1234_5678, 32'h0,       2'd0, 32'h8000_0000, 32'h3456_7800, 4'b0010, 32'h0,         2'b00, 0, 0, 0, 3);
        run_req("sw",  1, 2, 0, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,       2'd0, 32'h8000_0008, 32'hCAFE_F00D, 4'b1111, 32'h0,         2'b00, 1, 0, 1, 0);
        run_req("lwm", 0, 2, 0, 32'h8000_0001, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0,        4'b0000, 32'h0,         2'b01, 0, 0, 0, 1);
        run_req("shm", 1, 1, 0, 32'h8000_0003, 32'h0000_FFFF, 32'h0,       2'd0, 32'h0,         32'h0,        4'b0000, 32'h0,         2'b01, 0, 0, 0, 1);
        run_req("ld32",0, 3, 0, 32'h8000_0000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0,        4'b0000, 32'h0,         2'b01, 0, 0, 0, 1);
        run_req("lwe", 0, 2, 0, 32'h8000_0010, 32'h0,        32'h1111_1111, 2'd2, 32'h8000_0010, 32'h0,        4'b0000, 32'h0,         2'b10, 0, 0, 0, 3);
        run_req("swe", 1, 2, 0, 32'h8000_0014, 32'h5555_AAAA, 32'h0,       2'd3, 32'h8000_0014, 32'h5555_AAAA, 4'b1111, 32'h0,         2'b10, 0, 0, 0, 3);

        // Reset while waiting for read data: everything drops at once and
        // the aborted load never produces a response.
        start = resp_count;
        @(negedge clock);
        req_we = 0; req_size = 2; req_sext = 0; req_addr = 32'h8000_0020; req_valid = 1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 0;
        arready   = 1;
        @(negedge clock);
        arready = 0;
        check("abort_rready_before", rready, 1'b1);
        #2 reset = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h7777_7777;
        #1;
        check("abort_rready", rready, 1'b0);
        check("abort_req_ready", req_ready, 1'b0);
        check("abort_outputs", {resp_valid, arvalid, awvalid, wvalid, bready, wstrb}, 9'h0);
        check("abort_araddr", araddr, 32'h0);
        repeat (3) @(negedge clock);
        rvalid = 1'b0;
        rdata  = 32'h0;
        reset  = 1'b0;
        #1 check("abort_req_ready_after", req_ready, 1'b1);
        check("abort_no_resp", resp_count - start, 0);
        run_req("lw_post_rst", 0, 2, 0, 32'h8000_0024, 32'h0, 32'h0BAD_F00D, 2'd0, 32'h8000_0024,
                32'h0, 4'b0000, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 3);

        // 64-bit bus: unsigned word load from the upper half of a double.
        @(negedge clock);
        x_req_we = 0; x_req_size = 2; x_req_sext = 0; x_req_addr = 32'h8000_000C; x_req_valid = 1;
        check("w64_req_ready", x_req_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        x_req_valid = 0;
        check("w64_arvalid", x_arvalid, 1'b1);
        check("w64_araddr", x_araddr, 32'h8000_0008);
        x_arready = 1;
        @(negedge clock);
        x_arready = 0;
        x_rdata   = 64'h8765_4321_0000_0000;
        x_rvalid  = 1;
        @(negedge clock);
        x_rvalid = 0;
        check("w64_resp_valid", x_resp_valid, 1'b1);
        check("w64_resp_rdata", x_resp_rdata, 64'h0000_0000_8765_4321);
        check("w64_resp_err", x_resp_err, 2'b00);

        repeat (2) @(negedge clock);
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
